// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, optional zero pad, CRC-32 FCS and inter-frame gap.
// Define GMII_TX_PAD_EN to pad short frames up to PAD_MIN bytes.
module gmii_tx_framer #(
  parameter int PAD_MIN   = 60,
  parameter int IFG_BYTES = 12
) (
  input  logic        eth_tx_clk,
  input  logic        rst_n,
  input  logic [7:0]  i_tx_data,
  input  logic        i_tx_en,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_en,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt,
  output logic [7:0]  o_drop_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
`ifdef GMII_TX_PAD_EN
    ST_PAD  = 3'd3,
`endif
    ST_FCS  = 3'd4,
    ST_IFG  = 3'd5
  } state_e;

`ifdef GMII_TX_PAD_EN
  localparam logic [11:0] PAD_MIN_W  = 12'(PAD_MIN);
  localparam logic [11:0] PAD_LAST_W = 12'(PAD_MIN - 1);
`endif
  localparam logic [7:0]  IFG_LAST_W = 8'(IFG_BYTES - 1);

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
      else      c = c >> 1;
    end
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [11:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]      crc_q, crc_d;
  logic [7:0][8:0]  dl_q;
  logic             en_prev_q, accept_q, accept_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_en_q, tx_en_d, busy_q;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             rise_s, start_s, drop_s, accum_s;
  logic [8:0]       tail_s;
  logic [31:0]      fcs_s;

  // Edge detection, accept window and drop counting
  always_comb begin
    rise_s   = i_tx_en & ~en_prev_q;
    start_s  = rise_s & (state_q == ST_IDLE);
    drop_s   = rise_s & (state_q != ST_IDLE);
    accept_d = start_s | (accept_q & i_tx_en);
    tail_s   = dl_q[7];
    fcs_s    = ~crc_q;
    if (drop_s && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    else                                 drop_cnt_d = drop_cnt_q;
  end

  // Next-state and next-output logic; the byte chosen here appears on the wire next cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    tx_data_d   = 8'h00;
    tx_en_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;
    accum_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d    = ST_PRE;
          cnt_d      = 8'd1;
          byte_cnt_d = 12'd0;
          crc_d      = 32'hFFFFFFFF;
          tx_en_d    = 1'b1;
          tx_data_d  = 8'h55;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRE: begin
        tx_en_d = 1'b1;
        if (cnt_q == 8'd7) begin
          tx_data_d = 8'hD5;
          state_d   = ST_DATA;
          cnt_d     = 8'd0;
        end else begin
          tx_data_d = 8'h55;
          cnt_d     = cnt_q + 8'd1;
        end
      end
      ST_DATA: begin
        tx_en_d = 1'b1;
        if (tail_s[8]) begin
          tx_data_d = tail_s[7:0];
          accum_s   = 1'b1;
`ifdef GMII_TX_PAD_EN
        end else if (byte_cnt_q < PAD_MIN_W) begin
          tx_data_d = 8'h00;
          accum_s   = 1'b1;
          cnt_d     = 8'd0;
          if (byte_cnt_q >= PAD_LAST_W) state_d = ST_FCS;
          else                          state_d = ST_PAD;
`endif
        end else begin
          // First FCS byte goes out in the same cycle the data run ends
          tx_data_d = fcs_s[7:0];
          state_d   = ST_FCS;
          cnt_d     = 8'd1;
        end
      end
`ifdef GMII_TX_PAD_EN
      ST_PAD: begin
        tx_en_d   = 1'b1;
        tx_data_d = 8'h00;
        accum_s   = 1'b1;
        if (byte_cnt_q >= PAD_LAST_W) begin
          state_d = ST_FCS;
          cnt_d   = 8'd0;
        end else begin
          state_d = ST_PAD;
        end
      end
`endif
      ST_FCS: begin
        tx_en_d   = 1'b1;
        tx_data_d = fcs_s[{cnt_q[1:0], 3'b000} +: 8];
        if (cnt_q == 8'd3) begin
          state_d = ST_IFG;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_IFG: begin
        if (cnt_q == IFG_LAST_W) begin
          state_d     = ST_IDLE;
          cnt_d       = 8'd0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    if (accum_s) begin
      crc_d = crc32_byte(crc_q, tx_data_d);
      if (byte_cnt_q != 12'hFFF) byte_cnt_d = byte_cnt_q + 12'd1;
      else                       byte_cnt_d = byte_cnt_q;
    end else begin
      crc_d = crc_d;
    end
  end

  // State, delay line, counters and output registers
  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      byte_cnt_q  <= 12'd0;
      crc_q       <= 32'hFFFFFFFF;
      dl_q        <= '0;
      en_prev_q   <= 1'b1;  // an enable already high at release is not an edge
      accept_q    <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      dl_q        <= {dl_q[6:0], {i_tx_en & (accept_q | start_s), i_tx_data}};
      en_prev_q   <= i_tx_en;
      accept_q    <= accept_d;
      tx_data_q   <= tx_data_d;
      tx_en_q     <= tx_en_d;
      busy_q      <= (state_d != ST_IDLE);
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign o_tx_data   = tx_data_q;
  assign o_tx_en     = tx_en_q;
  assign o_busy      = busy_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: wire image, latency, IFG, drop and reset behaviour.
module tb_gmii_tx_framer;

`ifdef GMII_TX_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic        eth_tx_clk = 1'b0;
  logic        rst_n;
  logic [7:0]  i_tx_data;
  logic        i_tx_en;
  logic [7:0]  o_tx_data;
  logic        o_tx_en;
  logic        o_busy;
  logic [15:0] o_frame_cnt;
  logic [7:0]  o_drop_cnt;

  gmii_tx_framer dut (
    .eth_tx_clk (eth_tx_clk),
    .rst_n      (rst_n),
    .i_tx_data  (i_tx_data),
    .i_tx_en    (i_tx_en),
    .o_tx_data  (o_tx_data),
    .o_tx_en    (o_tx_en),
    .o_busy     (o_busy),
    .o_frame_cnt(o_frame_cnt),
    .o_drop_cnt (o_drop_cnt)
  );

  always #4 eth_tx_clk = ~eth_tx_clk;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int cyc = 0;
  int t0 = 0;
  int runs = 0;
  int first_en_cyc = 0;
  int last_en_cyc = 0;
  logic en_mon = 1'b0;
  logic [7:0] frame_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];

  always @(posedge eth_tx_clk) cyc <= cyc + 1;

  // Wire monitor: capture every byte with TX_EN high and count TX_EN runs
  always @(negedge eth_tx_clk) begin
    if (o_tx_en) begin
      if (!en_mon) begin
        runs = runs + 1;
        if (runs == 1) first_en_cyc = cyc;
      end
      cap_q.push_back(o_tx_data);
      last_en_cyc = cyc;
    end
    en_mon = o_tx_en;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [7:0] body[$]);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    foreach (body[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ body[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic clear_cap();
    cap_q.delete();
    runs = 0;
  endtask

  task automatic fill_seq(input int n, input int seed);
    logic [7:0] v;
    frame_q.delete();
    for (int i = 0; i < n; i++) begin
      v = 8'(seed + i * 37);
      frame_q.push_back(v);
    end
  endtask

  task automatic build_exp();
    logic [7:0] body[$];
    logic [31:0] fcs;
    body = frame_q;
    if (PAD_ON) while (body.size() < 60) body.push_back(8'h00);
    fcs = ref_crc(body);
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (body[i]) exp_q.push_back(body[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
  endtask

  // Called at a negedge; drives one byte per cycle, optionally asserting reset at byte rst_at
  task automatic drive_frame(input int rst_at);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == rst_at) begin
        rst_n   = 1'b0;
        i_tx_en = 1'b0;
        return;
      end
      if (i == 0) t0 = cyc;
      i_tx_en   = 1'b1;
      i_tx_data = frame_q[i];
      @(negedge eth_tx_clk);
    end
    i_tx_en = 1'b0;
  endtask

  task automatic verify_frame(input string tag, input int exp_len, input int exp_frames);
    int guard;
    int busy_fall;
    int mism;
    guard = 0;
    while (o_busy && guard < 3000) begin
      @(negedge eth_tx_clk);
      guard++;
    end
    check_val({tag, "_busy_timeout"}, {31'b0, o_busy}, 32'd0);
    busy_fall = cyc;
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) mism++;
    check_val({tag, "_runs"}, runs, 32'd1);
    check_val({tag, "_len"}, cap_q.size(), exp_len);
    check_val({tag, "_wire"}, mism, 32'd0);
    check_val({tag, "_en_lat"}, first_en_cyc - t0, 32'd1);
    check_val({tag, "_ifg"}, busy_fall - last_en_cyc, 32'd12);
    check_val({tag, "_frames"}, {16'h0, o_frame_cnt}, exp_frames);
  endtask

  initial begin
    logic [31:0] obs;
    string s;
    int g;
    rst_n = 1'b0;
    i_tx_en = 1'b0;
    i_tx_data = 8'h00;
    repeat (3) @(negedge eth_tx_clk);
    check_val("rst_en", {31'b0, o_tx_en}, 32'd0);
    check_val("rst_data", {24'b0, o_tx_data}, 32'd0);
    check_val("rst_busy", {31'b0, o_busy}, 32'd0);
    check_val("rst_frames", {16'b0, o_frame_cnt}, 32'd0);
    check_val("rst_drops", {24'b0, o_drop_cnt}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge eth_tx_clk);

    // CRC check value "123456789"
    s = "123456789";
    frame_q.delete();
    for (int i = 0; i < 9; i++) frame_q.push_back(s[i]);
    build_exp();
    clear_cap();
    drive_frame(-1);
    verify_frame("crc9", PAD_ON ? 72 : 21, 1);
    obs = 32'h0;
    if (cap_q.size() >= 4)
      obs = {cap_q[cap_q.size()-1], cap_q[cap_q.size()-2], cap_q[cap_q.size()-3], cap_q[cap_q.size()-4]};
    check_val("crc9_fcs", obs, PAD_ON ? ref_crc(exp_q[8:67]) : 32'hCBF43926);
    repeat (2) @(negedge eth_tx_clk);

    // ARP-size frame
    fill_seq(42, 3);
    build_exp();
    clear_cap();
    drive_frame(-1);
    verify_frame("arp", PAD_ON ? 72 : 54, 2);
    repeat (2) @(negedge eth_tx_clk);

    // UDP-size frame, never padded
    fill_seq(1082, 11);
    build_exp();
    clear_cap();
    drive_frame(-1);
    verify_frame("udp", 1094, 3);

    // Back-to-back: a start inside the IFG is dropped, the earliest legal start is framed
    fill_seq(20, 5);
    build_exp();
    clear_cap();
    drive_frame(-1);
    g = 0;
    while (o_tx_en && g < 200) begin
      @(negedge eth_tx_clk);
      g++;
    end
    check_val("b2b_en_fall", {31'b0, o_tx_en}, 32'd0);
    repeat (3) @(negedge eth_tx_clk);
    for (int i = 0; i < 4; i++) begin
      i_tx_en = 1'b1;
      i_tx_data = 8'hA0 + 8'(i);
      @(negedge eth_tx_clk);
    end
    i_tx_en = 1'b0;
    check_val("b2b_drop", {24'b0, o_drop_cnt}, 32'd1);
    verify_frame("b2b_a", PAD_ON ? 72 : 32, 4);
    fill_seq(60, 9);
    build_exp();
    clear_cap();
    drive_frame(-1);
    verify_frame("b2b_c", 72, 5);
    check_val("b2b_drop_after", {24'b0, o_drop_cnt}, 32'd1);
    repeat (2) @(negedge eth_tx_clk);

    // Reset while DATA byte 20 is on the wire
    fill_seq(64, 21);
    clear_cap();
    drive_frame(29);
    check_val("mid_was_en", {31'b0, en_mon}, 32'd1);
    #1;
    check_val("mid_rst_en", {31'b0, o_tx_en}, 32'd0);
    check_val("mid_rst_busy", {31'b0, o_busy}, 32'd0);
    check_val("mid_rst_frames", {16'b0, o_frame_cnt}, 32'd0);
    check_val("mid_rst_drops", {24'b0, o_drop_cnt}, 32'd0);
    repeat (3) @(negedge eth_tx_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge eth_tx_clk);
    fill_seq(64, 33);
    build_exp();
    clear_cap();
    drive_frame(-1);
    verify_frame("post_rst", 76, 1);

    // Enable held high across reset release is ignored and not counted
    i_tx_en = 1'b1;
    i_tx_data = 8'hAA;
    rst_n = 1'b0;
    repeat (3) @(negedge eth_tx_clk);
    rst_n = 1'b1;
    clear_cap();
    repeat (10) @(negedge eth_tx_clk);
    i_tx_en = 1'b0;
    repeat (3) @(negedge eth_tx_clk);
    check_val("held_runs", runs, 32'd0);
    check_val("held_busy", {31'b0, o_busy}, 32'd0);
    check_val("held_drops", {24'b0, o_drop_cnt}, 32'd0);
    fill_seq(61, 47);
    build_exp();
    clear_cap();
    drive_frame(-1);
    verify_frame("held_next", 73, 1);
    check_val("held_drops_end", {24'b0, o_drop_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
